// File: rtl/skew_pkg.sv
// rtl/skew_pkg.sv - shared FSM state type and row counter sizing for skew_buf
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int row_cnt_width(input int dim);
        return $clog2(dim + 1);
    endfunction

endpackage

// File: rtl/skew_delay.sv
// rtl/skew_delay.sv - one skew lane: shift-enabled register chain, optional tap select
// Optional feature: SKEW_BUF_DESKEW_EN adds sel to pick the reverse-skew tap.
module skew_delay #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 1
`ifdef SKEW_BUF_DESKEW_EN
    ,
    parameter int TAP_FWD = 1,
    parameter int TAP_REV = 1
`endif
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
`ifdef SKEW_BUF_DESKEW_EN
    input  logic                    sel,
`endif
    input  logic signed [WIDTH-1:0] d,
    output logic signed [WIDTH-1:0] q
);

    logic signed [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

`ifdef SKEW_BUF_DESKEW_EN
    assign q = sel ? stage[TAP_REV-1] : stage[TAP_FWD-1];
`else
    assign q = stage[DEPTH-1];
`endif

endmodule

// File: rtl/skew_buf.sv
// rtl/skew_buf.sv - row-to-parallelogram skew buffer feeding a systolic array
// Optional feature: SKEW_BUF_DESKEW_EN adds the deskew input (reverse skew per tile).
module skew_buf
    import skew_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SKEW_BUF_DESKEW_EN
    input  logic                      deskew,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BITS_AB-1:0] in_data [DIM],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [BITS_AB-1:0] out_data [DIM],
    output logic                      out_last,
    output logic                      busy
);

    localparam int CW = row_cnt_width(DIM);
    localparam logic [CW-1:0] ROWS       = CW'(DIM);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((DIM >= 2) ? DIM - 2 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, fcnt, fcnt_nxt;
    logic          en, accepting, step, tile_end;
    logic signed [BITS_AB-1:0] lane_in [DIM];
`ifdef SKEW_BUF_DESKEW_EN
    logic          deskew_q;
`endif

    assign en        = out_ready || !out_valid;
    assign accepting = (state == IDLE) || (state == LOAD);
    assign step      = en && ((accepting && in_valid) || (state == FLUSH));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fcnt_nxt  = fcnt;
        tile_end  = 1'b0;
        if (step) begin
            case (state)
                IDLE, LOAD: begin
                    if (cnt + CW'(1) == ROWS) begin
                        if (DIM == 1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            tile_end  = 1'b1;
                        end else begin
                            state_nxt = FLUSH;
                            cnt_nxt   = ROWS;
                        end
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
                FLUSH: begin
                    if (fcnt == FLUSH_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        fcnt_nxt  = '0;
                        tile_end  = 1'b1;
                    end else begin
                        fcnt_nxt  = fcnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = en && accepting;
        busy     = (state != IDLE);
    end

    // out_valid/out_last only move when the consumer can take a beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= '0;
            fcnt      <= '0;
        end else begin
            cnt  <= cnt_nxt;
            fcnt <= fcnt_nxt;
            if (en) begin
                out_valid <= step;
                out_last  <= tile_end;
            end
        end
    end

`ifdef SKEW_BUF_DESKEW_EN
    always_ff @(posedge clk) begin
        if (rst)                        deskew_q <= 1'b0;
        else if (state == IDLE && step) deskew_q <= deskew;
    end
`endif

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        assign lane_in[i] = (state == FLUSH) ? '0 : in_data[i];
`ifdef SKEW_BUF_DESKEW_EN
        localparam int DEPTH = (i + 1 > DIM - i) ? i + 1 : DIM - i;
        skew_delay #(
            .WIDTH  (BITS_AB),
            .DEPTH  (DEPTH),
            .TAP_FWD(i + 1),
            .TAP_REV(DIM - i)
        ) u_lane (
            .clk(clk),
            .clr(rst),
            .en (step),
            .sel(deskew_q),
            .d  (lane_in[i]),
            .q  (out_data[i])
        );
`else
        skew_delay #(
            .WIDTH(BITS_AB),
            .DEPTH(i + 1)
        ) u_lane (
            .clk(clk),
            .clr(rst),
            .en (step),
            .d  (lane_in[i]),
            .q  (out_data[i])
        );
`endif
    end

endmodule
